// File: rtl/rv32_wb_unit.sv
// Write-back unit: owns the regfile write port, merges ALU and MUL/DIV results
// through a small result FIFO, and tracks outstanding long-latency writes.
module rv32_wb_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            iss_valid_i,
  input  logic            iss_long_i,
  input  logic [4:0]      iss_rd_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_val_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_val_i,
  output logic            we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] val_rd_o,
  output logic [31:0]     busy_o,
  output logic            fifo_full_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [4:0]      fifo_rd  [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_val [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            push, pop, alu_grant;
  logic [4:0]      head_rd;
  logic [31:0]     busy_q, busy_nxt;
  logic            full_q;

  // Ready depends on occupancy only, never on md_valid_i.
  assign md_ready_o = rst_n_i & (count < DEPTH_C);
  assign alu_grant  = alu_valid_i & (alu_rd_i != 5'd0);
  assign push       = md_valid_i & md_ready_o;
  assign pop        = ~alu_grant & (count != '0);
  assign head_rd    = fifo_rd[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Set after clear: a newer long op re-targeting the register keeps it busy.
  always_comb begin
    busy_nxt = busy_q;
    if (pop && head_rd != 5'd0)
      busy_nxt[head_rd] = 1'b0;
    if (iss_valid_i && iss_long_i && iss_rd_i != 5'd0)
      busy_nxt[iss_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= md_rd_i;
      fifo_val[wr_ptr] <= md_val_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      busy_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == DEPTH_C);
      busy_q <= busy_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_o      <= 1'b0;
      rd_addr_o <= '0;
      val_rd_o  <= '0;
    end else if (alu_grant) begin
      we_o      <= 1'b1;
      rd_addr_o <= alu_rd_i;
      val_rd_o  <= alu_val_i;
    end else if (pop && head_rd != 5'd0) begin
      we_o      <= 1'b1;
      rd_addr_o <= head_rd;
      val_rd_o  <= fifo_val[rd_ptr];
    end else begin
      we_o      <= 1'b0;
    end
  end

  assign busy_o      = busy_q;
  assign fifo_full_o = full_q;

endmodule

// File: tb/tb_rv32_wb_unit.sv
// Directed bench for rv32_wb_unit: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points.
module tb_rv32_wb_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iss_valid = 1'b0, iss_long = 1'b0;
  logic [4:0]      iss_rd = '0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_val = '0;
  logic            md_valid = 1'b0;
  logic            md_ready;
  logic [4:0]      md_rd = '0;
  logic [XLEN-1:0] md_val = '0;
  logic            we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] val_rd;
  logic [31:0]     busy;
  logic            fifo_full;

  int checks = 0;
  int errors = 0;

  rv32_wb_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .iss_valid_i(iss_valid), .iss_long_i(iss_long), .iss_rd_i(iss_rd),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_val_i(alu_val),
    .md_valid_i(md_valid), .md_ready_o(md_ready), .md_rd_i(md_rd), .md_val_i(md_val),
    .we_o(we), .rd_addr_o(rd_addr), .val_rd_o(val_rd),
    .busy_o(busy), .fifo_full_o(fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [XLEN-1:0] val; } res_t;
  res_t            mq[$];
  logic            m_we = 1'b0;
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_val = '0;
  logic [31:0]     m_busy = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results are a queue, the register file write is whatever wins.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_rd = '0; m_val = '0; m_busy = '0;
    end else begin
      res_t head;
      bit   take_md;
      bit   popped;
      take_md = md_valid && (mq.size() < DEPTH);
      popped  = 1'b0;
      m_we    = 1'b0;
      if (alu_valid && alu_rd != 0) begin
        m_we = 1'b1; m_rd = alu_rd; m_val = alu_val;
      end else if (mq.size() > 0) begin
        head = mq.pop_front();
        popped = 1'b1;
        if (head.rd != 0) begin
          m_we = 1'b1; m_rd = head.rd; m_val = head.val;
          m_busy[head.rd] = 1'b0;
        end
      end
      if (iss_valid && iss_long && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (take_md) mq.push_back('{md_rd, md_val});
      if (popped) ; // head already consumed
    end
  end

  always @(negedge clk) begin
    chk("we", 64'(we), 64'(m_we));
    chk("rd_addr", 64'(rd_addr), 64'(m_rd));
    chk("val_rd", 64'(val_rd), 64'(m_val));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
    chk("md_ready", 64'(md_ready), 64'(rst_n && (mq.size() < DEPTH)));
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Hold a MUL/DIV result until it transfers; bounded wait.
  task automatic md_push(input logic [4:0] rd, input logic [XLEN-1:0] val);
    bit xfer;
    bit done;
    done = 1'b0;
    md_valid = 1'b1; md_rd = rd; md_val = val;
    for (int n = 0; n < 50; n++) begin
      xfer = md_ready;
      step();
      if (xfer) begin done = 1'b1; break; end
    end
    md_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL md_push_timeout: rd %0d not accepted within 50 cycles", rd);
    end
  endtask

  initial begin
    step(); step();
    chk("reset_we", 64'(we), 64'd0);
    chk("reset_ready", 64'(md_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", 64'(md_ready), 64'd1);

    // ALU path: xi gets (i+1)*12 on consecutive cycles
    alu_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      alu_rd = 5'(i); alu_val = XLEN'((i + 1) * 12);
      step();
    end
    alu_valid = 1'b0;
    chk("alu_last_rd", 64'(rd_addr), 64'd31);
    chk("alu_last_val", 64'(val_rd), 64'd384);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_val = 654;
    step();
    alu_valid = 1'b0;
    chk("alu_x0_we", 64'(we), 64'd0);
    chk("alu_x0_hold", 64'(val_rd), 64'd384);
    step();

    // Long op and scoreboard
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd5;
    step();
    iss_valid = 1'b0;
    chk("busy5_set", 64'(busy[5]), 64'd1);
    md_push(5'd5, 546);
    chk("md5_not_yet", 64'(we), 64'd0);
    step();
    chk("md5_we", 64'(we), 64'd1);
    chk("md5_rd", 64'(rd_addr), 64'd5);
    chk("md5_val", 64'(val_rd), 64'd546);
    chk("busy5_clear", 64'(busy[5]), 64'd0);
    step();

    // Contention: ALU holds port for 3 cycles, then queued x3 drains
    alu_valid = 1'b1; alu_rd = 5'd4; alu_val = 44;
    md_push(5'd3, 7);
    step(); step();
    chk("cont_alu_rd", 64'(rd_addr), 64'd4);
    alu_valid = 1'b0;
    step();
    chk("cont_md_rd", 64'(rd_addr), 64'd3);
    chk("cont_md_val", 64'(val_rd), 64'd7);
    step();

    // Fill FIFO while the ALU blocks pops; third result waits for space
    alu_valid = 1'b1; alu_rd = 5'd4; alu_val = 45;
    md_push(5'd7, 70);
    md_push(5'd8, 80);
    chk("full_flag", 64'(fifo_full), 64'd1);
    chk("full_ready", 64'(md_ready), 64'd0);
    fork
      md_push(5'd9, 90);
      begin step(); step(); alu_valid = 1'b0; end
    join
    repeat (4) step();
    chk("drain_rd", 64'(rd_addr), 64'd9);
    chk("drain_val", 64'(val_rd), 64'd90);

    // Set/clear race on x6
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd6;
    step();
    iss_valid = 1'b0;
    md_push(5'd6, 66);
    iss_valid = 1'b1; iss_rd = 5'd6;
    step();
    iss_valid = 1'b0;
    chk("race_we", 64'(we), 64'd1);
    chk("race_rd", 64'(rd_addr), 64'd6);
    chk("race_busy6", 64'(busy[6]), 64'd1);
    step();

    // x0 MUL/DIV result and x0 long issue
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd0;
    md_push(5'd0, 5);
    iss_valid = 1'b0;
    chk("x0_busy0", 64'(busy[0]), 64'd0);
    step();
    chk("x0_we", 64'(we), 64'd0);
    step();

    // Reset mid-run with two results queued
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd11;
    step();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_val = 46;
    md_push(5'd11, 110);
    md_push(5'd12, 120);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(md_ready), 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    alu_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_stale_we", 64'(we), 64'd0);
    chk("no_stale_rd", 64'(rd_addr), 64'd0);
    chk("post_rst_ready", 64'(md_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_wb_unit.md
# rv32_wb_unit

Write-back unit that owns the single write port of `rv32im_regfile`. It merges single-cycle ALU results with multi-cycle MUL/DIV results and drives `we_i`/`rd_addr_i`/`val_rd_i` from registers. A small FIFO buffers MUL/DIV results, and a per-register busy scoreboard lets the issue stage detect RAW hazards on outstanding long-latency writes. It sits between the execute stage and the register file.

## Interface
- `XLEN`, default 32: data width.
- `FIFO_DEPTH`, default 2: MUL/DIV result buffer entries. Must be a power of two, at least 2.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `iss_valid_i`  in  1  an instruction issues this cycle.
- `iss_long_i`  in  1  the issuing instruction is MUL/DIV; qualified by `iss_valid_i`.
- `iss_rd_i`  in  5  destination register of the issuing instruction.
- `alu_valid_i`  in  1  ALU result valid; no back-pressure.
- `alu_rd_i`  in  5  ALU destination register.
- `alu_val_i`  in  XLEN  ALU result.
- `md_valid_i`  in  1  MUL/DIV result valid.
- `md_ready_o`  out  1  FIFO can accept a MUL/DIV result.
- `md_rd_i`  in  5  MUL/DIV destination register.
- `md_val_i`  in  XLEN  MUL/DIV result.
- `we_o`  out  1  connects to regfile `we_i`; registered.
- `rd_addr_o`  out  5  connects to regfile `rd_addr_i`; registered.
- `val_rd_o`  out  XLEN  connects to regfile `val_rd_i`; registered.
- `busy_o`  out  32  scoreboard; bit n = long-latency write to xn outstanding.
- `fifo_full_o`  out  1  FIFO holds `FIFO_DEPTH` entries; the issue stage stalls long ops on this.

## Operation
- **MUL/DIV handshake:** a transfer occurs when `md_valid_i && md_ready_o`. `md_ready_o` = (count < `FIFO_DEPTH`) and is forced to 0 while `rst_n_i` is low. The producer holds rd/val stable until the transfer. The FIFO is circular with wrapping pointers and a count of `$clog2(FIFO_DEPTH)+1` bits.
- **Write-port arbitration (per cycle), strict ALU priority:**
  - If `alu_valid_i` and `alu_rd_i != 0`: the ALU owns the port and the FIFO does not pop.
  - Otherwise, if the FIFO is non-empty: pop the head.
  - Otherwise: idle.
  - An ALU result with rd = 0 is discarded and does not block a pop.
- **Output register (next cycle):**
  - ALU grant: `we_o=1`, rd/val from the ALU.
  - Pop with rd != 0: `we_o=1`, rd/val from the head.
  - Pop with rd = 0: entry discarded, `we_o=0`.
  - Idle: `we_o=0`; `rd_addr_o` and `val_rd_o` hold their previous values.
  - `we_o` is never 1 with `rd_addr_o=0`.
- **Simultaneous push and pop:** both occur and the count is unchanged. Pushing into a full FIFO is impossible because ready is low.
- **Scoreboard:**
  - Set: `iss_valid_i && iss_long_i && iss_rd_i != 0` sets `busy[iss_rd_i]`.
  - Clear: a pop with rd != 0 clears `busy[rd]` in the same edge that loads the output register.
  - Set and clear of the same index in one cycle: set wins, because a newer long op re-targets the register.
  - `busy_o[0]` is constant 0.
  - The ALU never touches the scoreboard.
- **Reset (asynchronous, any time, including mid-pop):**
  - `we_o=0`, `rd_addr_o=0`, `val_rd_o=0`, `busy_o=0`, `fifo_full_o=0`, `md_ready_o=0`.
  - FIFO pointers and count cleared; pending results are lost.
  - After release, `md_ready_o=1` from the first cycle.

## Timing
- ALU result presented in cycle N: `we_o` high in N+1, and the regfile holds the value after the N+1 edge.
- MUL/DIV result into an empty FIFO with no ALU contention: pushed at the end of N, popped in N+1, `we_o` high in N+2.
- Each cycle the ALU holds the port adds one cycle of MUL/DIV latency. There is no starvation guard; the issue stage throttles using `fifo_full_o`.
- `busy_o` and `fifo_full_o` are registered state. `md_ready_o` is combinational from the count only, with no path from `md_valid_i`.

## Test plan
- **Reset:** assert `rst_n_i=0` mid-run with 2 FIFO entries queued -> immediately `we_o=0`, `busy_o=0`, `md_ready_o=0`. After release, no stale write appears.
- **ALU path:** ALU writes x1..x31 with value (i+1)*12 on consecutive cycles -> each `we_o` lags by one cycle with the matching rd/val. An ALU write with rd=0, value 654 -> `we_o` stays 0.
- **Long op and scoreboard:**
  - Issue long to x5 -> `busy_o[5]=1` next cycle.
  - `md` result x5 = 546 with no ALU traffic -> `we_o=1`, rd=5, val=546 two cycles after `md_valid_i`; `busy_o[5]` drops on the same edge.
- **Contention:**
  - `md` x3=7 queued while the ALU writes x4 for 3 cycles -> x4 is written 3 times first, then x3=7.
  - Fill the FIFO -> `fifo_full_o=1` and `md_ready_o=0`; the held `md` result transfers once a pop frees an entry.
- **Set/clear race:** pop of x6 in the same cycle as a new long issue to x6 -> `busy_o[6]` remains 1.
- **x0 MUL/DIV:** `md` result to x0 -> popped and discarded with no `we_o` pulse; `busy_o[0]` is always 0.
